// File: rtl/instr_decode.sv
// Two-stage instruction decoder: fetches 16-bit words (one or two per instruction),
// then drives register-file selects, write enable, immediate and ALU function for one EXEC cycle.
module instr_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  input  logic        STALL,
  output logic [2:0]  RS1,
  output logic [2:0]  RS2,
  output logic [2:0]  WS,
  output logic        WE,
  output logic [15:0] IMM,
  output logic        IMM_SEL,
  output logic [2:0]  ALU_OP,
  output logic        HE,
  output logic        ILL,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_IMM   = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_MOV  = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Handshake: a word transfers on a rising edge where INSTR_VALID and INSTR_READY are both 1;
  // INSTR_READY never depends on INSTR_VALID.
  logic [1:0]  state;
  logic [15:0] ir;
  logic [15:0] imm_reg;
  logic [2:0]  rs1_q, rs2_q, ws_q, alu_op_q;
  logic        ill_q;
  logic        accept;
  logic        in_exec;
  logic [3:0]  ir_op;
  logic [3:0]  in_op;
  logic [2:0]  ir_alu_op;
  logic        ir_writes;

  assign INSTR_READY = ((state == ST_FETCH) || (state == ST_IMM)) && !STALL;
  assign accept      = INSTR_VALID && INSTR_READY;
  assign in_exec     = (state == ST_EXEC);
  assign ir_op       = ir[15:12];
  assign in_op       = INSTR[15:12];
  assign ir_alu_op   = (ir_op == OP_ALU) ? ir[2:0] : 3'b000;
  assign ir_writes   = (ir_op == OP_ALU) || (ir_op == OP_MOV) || (ir_op == OP_LDI);

  // Outside EXEC the selects keep the values they had during the last EXEC cycle.
  assign RS1     = in_exec ? ir[8:6]   : rs1_q;
  assign RS2     = in_exec ? ir[5:3]   : rs2_q;
  assign WS      = in_exec ? ir[11:9]  : ws_q;
  assign ALU_OP  = in_exec ? ir_alu_op : alu_op_q;
  assign IMM_SEL = in_exec && (ir_op == OP_LDI);
  assign WE      = in_exec && !STALL && ir_writes && (ir[11:9] != 3'b000);
  assign IMM     = imm_reg;
  assign HE      = (state == ST_HALT);
  assign ILL     = ill_q;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FETCH;
      ir       <= 16'h0000;
      imm_reg  <= 16'h0000;
      rs1_q    <= 3'b000;
      rs2_q    <= 3'b000;
      ws_q     <= 3'b000;
      alu_op_q <= 3'b000;
      ill_q    <= 1'b0;
    end else begin
      ill_q <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (accept) begin
            case (in_op)
              OP_LDI: begin
                ir    <= INSTR;
                state <= ST_IMM;
              end
              OP_NOP, OP_ALU, OP_MOV: begin
                ir    <= INSTR;
                state <= ST_EXEC;
              end
              OP_HALT: state <= ST_HALT;
              default: ill_q <= 1'b1;
            endcase
          end
        end
        ST_IMM: begin
          if (accept) begin
            imm_reg <= INSTR;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rs1_q    <= ir[8:6];
          rs2_q    <= ir[5:3];
          ws_q     <= ir[11:9];
          alu_op_q <= ir_alu_op;
          if (!STALL) state <= ST_FETCH;
        end
        default: state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 INSTR  in  16  instruction word from fetch.
REQ-005 INSTR_VALID  in  1  INSTR holds a valid word.
REQ-006 INSTR_READY  out  1  decoder accepts INSTR this cycle.
REQ-007 STALL  in  1  downstream hold request.
REQ-008 RS1, RS2  out  3 each  register-file read selects.
REQ-009 WS  out  3  register-file write select.
REQ-010 WE  out  1  register-file write enable.
REQ-011 IMM  out  16  immediate word for the write path.
REQ-012 IMM_SEL  out  1  1 selects IMM over the ALU result as the register-file IN.
REQ-013 ALU_OP  out  3  ALU function code.
REQ-014 HE  out  1  halt enable to the register file.
REQ-015 ILL  out  1  one-cycle illegal-opcode pulse.

Function
REQ-016 Instruction fields SHALL be: [15:12] opcode, [11:9] WS, [8:6] RS1, [5:3] RS2, [2:0] func.
REQ-017 Opcodes SHALL be: 0x0 NOP; 0x1 ALU (ALU_OP=func, write); 0x2 LDI (two-word, the second word is the immediate, write with IMM_SEL=1); 0x3 MOV (ALU_OP=000 pass RS1, write); 0xF HALT; all others illegal.
REQ-018 The FSM SHALL have the states FETCH, IMM, EXEC and HALT.
REQ-019 A word SHALL be accepted on any rising edge with INSTR_VALID=1 and INSTR_READY=1.
REQ-020 INSTR_READY SHALL equal (state==FETCH or state==IMM) and STALL=0.
REQ-021 FETCH transitions:
- Accepted LDI: latch the word into the instruction register (IR) and go to IMM.
- Accepted NOP, ALU or MOV: latch IR and go to EXEC.
- Accepted HALT: go to HALT.
- Accepted illegal opcode: pulse ILL the next cycle and stay in FETCH.
- Otherwise: hold.
REQ-022 IMM: an accepted word SHALL be latched into the IMM register, with the next state EXEC; otherwise hold.
REQ-023 In EXEC, RS1, RS2, WS, ALU_OP and IMM_SEL SHALL be driven from IR; IMM is driven from the IMM register.
REQ-024 WE SHALL be 1 only in EXEC with STALL=0, opcode ALU, MOV or LDI, and WS!=000.
REQ-025 WE is 0 for a NOP.
REQ-026 EXEC with STALL=0 SHALL return to FETCH on the next edge; EXEC with STALL=1 holds all outputs, with WE=0.
REQ-027 Latency: a single-word instruction accepted at edge N SHALL produce WE=1 during cycle N+1 if STALL=0; LDI second word accepted at edge N gives the same.
REQ-028 Throughput SHALL be at most one single-word instruction per 2 cycles.
REQ-029 Outside EXEC, WE=0, IMM_SEL=0, and RS1/RS2/WS/ALU_OP hold their last values.
REQ-030 HALT: HE=1, INSTR_READY=0, WE=0; the block SHALL leave HALT only on rst.
REQ-031 ILL SHALL be high for exactly one cycle per illegal word, and no register write results.
REQ-032 STALL SHALL never cause a word to be lost or duplicated; an accepted word is processed exactly once.

Reset
REQ-033 On a rising edge with rst=1, the block SHALL go to FETCH and clear IR and IMM to 0x0000.
REQ-034 That reset SHALL also clear RS1, RS2, WS and ALU_OP to 000, and clear WE, IMM_SEL, HE and ILL to 0.
REQ-035 After reset, INSTR_READY=1 when STALL=0.
REQ-036 rst SHALL override all other inputs, including in HALT.
REQ-037 A reset in IMM SHALL discard the pending LDI, with no write.

Verification
REQ-038 Single write: after rst, feed INSTR=0x1299 (ALU, WS=001, RS1=010, RS2=011, func=001) -> next cycle WE=1, WS=001, RS1=010, RS2=011, ALU_OP=001, IMM_SEL=0.
REQ-039 LDI: feed 0x2400 then 0xBEEF, with INSTR_VALID deasserted for 2 cycles between the words -> INSTR_READY stays 1 in IMM; after the second accept, WE=1, WS=010, IMM=0xBEEF, IMM_SEL=1.
REQ-040 STALL: accept 0x3680 (MOV WS=011, RS1=010), hold STALL=1 for 3 cycles -> WE=0 and outputs stable during the stall; WE=1 in the first cycle after STALL falls; exactly one write.
REQ-041 Zero target and NOP: 0x1000 and 0x0000 -> WE stays 0; INSTR_READY returns to 1 after 2 cycles.
REQ-042 Illegal then HALT: 0x7000 -> ILL=1 for one cycle, no WE; then 0xF000 -> HE=1, INSTR_READY=0 indefinitely; rst -> HE=0, INSTR_READY=1.
REQ-043 Reset mid-LDI: accept 0x2200, assert rst -> no WE; state FETCH; a following 0x1299 decodes as in REQ-038.
